nios_system_sysid_ext: RTL and testbench

//  Parametrised system-ID/info slave on the Nios Avalon-MM fabric; successor to the fixed 1-word sysid.

---
 rtl/nios_system_sysid_ext_if.sv | 20 ++
 rtl/nios_system_sysid_ext.sv | 121 ++++++++++++
 tb/tb_nios_system_sysid_ext.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM slave port bundle for the extended system-ID block.
interface nios_system_sysid_ext_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/nios_system_sysid_ext.sv
// System ID/info slave: ID, timestamp, caps, coherent uptime counter, CTRL, optional scratch (SYSID_SCRATCH_EN).
// Latency: registered read data, readdatavalid one cycle after an accepted read.
// Backpressure: none; no waitrequest, every strobe is accepted in the cycle it is presented.
module nios_system_sysid_ext #(
    parameter logic [31:0] SYS_ID    = 32'h5716_3A7B,
    parameter logic [31:0] TIMESTAMP = 32'h0,
    parameter logic [15:0] CAPS      = 16'h0001,
    parameter int          COUNT_W   = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    nios_system_sysid_ext_if.slave bus
);

    localparam int          HI_W      = COUNT_W - 32;
    localparam logic [7:0]  COUNT_W_B = 8'(COUNT_W);
    localparam logic [2:0]  A_SYS_ID  = 3'd0;
    localparam logic [2:0]  A_TSTAMP  = 3'd1;
    localparam logic [2:0]  A_CAPS    = 3'd2;
    localparam logic [2:0]  A_UP_LO   = 3'd3;
    localparam logic [2:0]  A_UP_HI   = 3'd4;
    localparam logic [2:0]  A_SCRATCH = 3'd5;
    localparam logic [2:0]  A_CTRL    = 3'd6;

`ifdef SYSID_SCRATCH_EN
    localparam logic SCRATCH_PRESENT = 1'b1;
`else
    localparam logic SCRATCH_PRESENT = 1'b0;
`endif

    logic [COUNT_W-1:0] cnt;
    logic [HI_W-1:0]    shadow;
    logic               freeze;
    logic [31:0]        scratch_rd;
    logic [31:0]        rd_mux;
    logic               rd_acc;
    logic               ctrl_wr;
    logic               clear;

    // A read colliding with a write is dropped; the write still lands.
    assign rd_acc  = bus.read & ~bus.write;
    assign ctrl_wr = bus.write && (bus.address == A_CTRL) && bus.byteenable[0];
    assign clear   = ctrl_wr & bus.writedata[0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= cnt + COUNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            freeze <= 1'b0;
        end else if (ctrl_wr) begin
            freeze <= bus.writedata[1];
        end
    end

    // High word is captured from the same snapshot that the low-word read returns.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (rd_acc && (bus.address == A_UP_LO)) begin
            shadow <= cnt[COUNT_W-1:32];
        end
    end

`ifdef SYSID_SCRATCH_EN
    logic [31:0] scratch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scratch <= '0;
        end else if (bus.write && (bus.address == A_SCRATCH)) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) begin
                    scratch[b*8 +: 8] <= bus.writedata[b*8 +: 8];
                end
            end
        end
    end

    assign scratch_rd = scratch;
`else
    logic unused_bits;

    assign scratch_rd  = '0;
    assign unused_bits = ^{bus.writedata[31:2], bus.byteenable[3:1]};
`endif

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_SYS_ID:  rd_mux = SYS_ID;
            A_TSTAMP:  rd_mux = TIMESTAMP;
            A_CAPS:    rd_mux = {COUNT_W_B, 7'b0, SCRATCH_PRESENT, CAPS};
            A_UP_LO:   rd_mux = cnt[31:0];
            A_UP_HI:   rd_mux = 32'(shadow);
            A_SCRATCH: rd_mux = scratch_rd;
            A_CTRL:    rd_mux = {30'b0, freeze, 1'b0};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= rd_acc;
            if (rd_acc) begin
                bus.readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Directed self-checking bench for the extended system-ID slave.
module tb_nios_system_sysid_ext;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    nios_system_sysid_ext_if bus ();

    nios_system_sysid_ext dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef SYSID_SCRATCH_EN
    localparam logic [31:0] CAPS_EXP = 32'h4001_0001;
`else
    localparam logic [31:0] CAPS_EXP = 32'h4000_0001;
`endif

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One bus cycle: inputs change at the falling edge, sampled at the next rising edge.
    task automatic cyc(input logic r, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        bus.read       = r;
        bus.write      = w;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        cyc(1'b0, 1'b1, a, d, be);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        cyc(1'b1, 1'b0, a, 32'h0, 4'h0);
        idle();
        check({tag, "_vld"}, 32'(bus.readdatavalid), 32'd1);
        check(tag, bus.readdata, exp);
    endtask

    logic [31:0] frz_a;
    logic        seen_vld;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0;
        bus.writedata = '0; bus.byteenable = '0;

        repeat (2) @(negedge clock);
        check("rst_rdata", bus.readdata, 32'h0);
        check("rst_rvld", 32'(bus.readdatavalid), 32'd0);

        // First cycle after release sees uptime 0.
        @(negedge clock);
        reset = 1'b0; bus.read = 1'b1; bus.address = 3'd3;
        idle();
        check("rst_uptime", bus.readdata, 32'h0);

        // T1: back-to-back reads, one response per cycle.
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        cyc(1'b1, 1'b0, 3'd1, 32'h0, 4'h0);
        check("t1_vld0", 32'(bus.readdatavalid), 32'd1);
        check("t1_sysid", bus.readdata, 32'h5716_3A7B);
        cyc(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        check("t1_vld1", 32'(bus.readdatavalid), 32'd1);
        check("t1_tstamp", bus.readdata, 32'h0);
        idle();
        check("t1_vld2", 32'(bus.readdatavalid), 32'd1);
        check("t1_caps", bus.readdata, CAPS_EXP);
        idle();
        check("t1_vld_drop", 32'(bus.readdatavalid), 32'd0);
        check("t1_hold", bus.readdata, CAPS_EXP);

        // T2: preset counter near the low-word carry and check shadow coherency.
        @(negedge clock);
        force dut.cnt = 64'h0000_0000_FFFF_FFFE;
        bus.read = 1'b1; bus.write = 1'b0; bus.address = 3'd3;
        #1 release dut.cnt;
        idle();
        check("t2_lo", bus.readdata, 32'hFFFF_FFFE);
        repeat (3) idle();
        rd_chk("t2_hi_shadow", 3'd4, 32'h0);
        rd_chk("t2_lo2", 3'd3, 32'h0000_0005);
        rd_chk("t2_hi2", 3'd4, 32'h0000_0001);

        // T3: freeze, clear under freeze, then clear while running.
        wr(3'd6, 32'h2, 4'b0001);
        repeat (10) idle();
        cyc(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        idle();
        frz_a = bus.readdata;
        repeat (4) idle();
        rd_chk("t3_frozen", 3'd3, frz_a);
        rd_chk("t3_ctrl_rd", 3'd6, 32'h2);
        wr(3'd6, 32'h3, 4'b0001);
        rd_chk("t3_clr_frozen", 3'd3, 32'h0);
        repeat (3) idle();
        rd_chk("t3_clr_stays", 3'd3, 32'h0);
        rd_chk("t3_ctrl_selfclr", 3'd6, 32'h2);
        wr(3'd6, 32'h0, 4'b0001);
        wr(3'd6, 32'h1, 4'b0001);
        rd_chk("t3_clr_run0", 3'd3, 32'h0);
        rd_chk("t3_clr_run2", 3'd3, 32'h2);
        wr(3'd6, 32'h2, 4'b1110);
        rd_chk("t3_ctrl_be0", 3'd6, 32'h0);

        // T4: scratch byte lanes.
        wr(3'd5, 32'hDEAD_BEEF, 4'b1111);
        wr(3'd5, 32'h0000_0012, 4'b0001);
`ifdef SYSID_SCRATCH_EN
        rd_chk("t4_scratch", 3'd5, 32'hDEAD_BE12);
        wr(3'd5, 32'h0077_0000, 4'b0100);
        rd_chk("t4_scratch_b2", 3'd5, 32'hDE77_BE12);
`else
        rd_chk("t4_scratch", 3'd5, 32'h0);
`endif
        rd_chk("t4_caps", 3'd2, CAPS_EXP);

        // T5: RO/reserved writes, reserved reads.
        wr(3'd0, 32'h0, 4'b1111);
        wr(3'd7, 32'hFFFF_FFFF, 4'b1111);
        rd_chk("t5_sysid_ro", 3'd0, 32'h5716_3A7B);
        rd_chk("t5_resv", 3'd7, 32'h0);

        // Read+write collision: write lands, read gets no response.
        cyc(1'b1, 1'b1, 3'd6, 32'h2, 4'b0001);
        idle();
        check("rw_no_vld", 32'(bus.readdatavalid), 32'd0);
        rd_chk("rw_write_done", 3'd6, 32'h2);

        // T6: reset in the cycle after a read cancels the response.
        wr(3'd5, 32'h1234_5678, 4'b1111);
        cyc(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        #2 reset = 1'b1;
        seen_vld = 1'b0;
        repeat (3) begin
            @(negedge clock);
            bus.read = 1'b0;
            seen_vld = seen_vld | bus.readdatavalid;
        end
        @(negedge clock);
        seen_vld = seen_vld | bus.readdatavalid;
        reset = 1'b0; bus.read = 1'b1; bus.address = 3'd3;
        check("t6_no_vld", 32'(seen_vld), 32'd0);
        idle();
        check("t6_uptime", bus.readdata, 32'h0);
        rd_chk("t6_ctrl", 3'd6, 32'h0);
        rd_chk("t6_scratch", 3'd5, 32'h0);
        rd_chk("t6_shadow", 3'd4, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
